// File: rtl/weightmem_read_sequencer.sv
// Read initiator for one weight SRAM bank: streams base..base+N-1 through a 2-entry skid FIFO.
// Optional multi-pass replay of a command is enabled by defining WEIGHTMEM_READ_SEQUENCER_REPEAT_EN.
module weightmem_read_sequencer #(
  parameter int NUM_WORDS  = 1024,
  parameter int DATA_WIDTH = 80,
  parameter int FIFO_DEPTH = 2,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   num_words_i,
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
  input  logic [7:0]            repeat_i,
`endif
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
  localparam int OUT_W = ADDR_WIDTH + 10;
`else
  localparam int OUT_W = ADDR_WIDTH + 1;
`endif
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = OCC_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_issue_q;
  logic [OUT_W-1:0]      rem_out_q;
  logic                  inflight_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [7:0]            pass_q;
`endif

  logic             push;
  logic             pop;
  logic             last_pop;
  logic [CRD_W-1:0] credit;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(NUM_WORDS - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  assign push     = inflight_q;
  assign valid_o  = (occ_q != '0);
  assign pop      = valid_o && ready_i;
  assign last_o   = valid_o && (rem_out_q == OUT_W'(1));
  assign last_pop = last_o && ready_i;
  assign data_o   = fifo_q[rd_ptr_q];

  // Credit counts words already buffered plus the one returning this cycle; a slot freed by
  // this cycle's pop can be reused immediately, which keeps the stream at one word per cycle.
  assign credit    = CRD_W'(occ_q) + CRD_W'(inflight_q) - CRD_W'(pop);
  assign mem_req_o = (state_q == RUN) && !flush_i && (rem_issue_q != '0)
                     && (credit < CRD_W'(FIFO_DEPTH));
  assign mem_addr_o = addr_q;
  assign mem_we_o   = 1'b0;
  assign mem_be_o   = '1;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
      base_addr_q <= '0;
      num_q       <= '0;
      pass_q      <= '0;
`endif
    end else if (flush_i) begin
      // Dropping inflight_q discards the read that returns during the flush cycle.
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
      base_addr_q <= '0;
      num_q       <= '0;
      pass_q      <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      inflight_q <= mem_req_o;

      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rem_out_q <= rem_out_q - OUT_W'(1);
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);

      if (mem_req_o) begin
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
        if ((rem_issue_q == (ADDR_WIDTH+1)'(1)) && (pass_q != '0)) begin
          addr_q      <= base_addr_q;
          rem_issue_q <= num_q;
          pass_q      <= pass_q - 8'd1;
        end else begin
          addr_q      <= next_addr(addr_q);
          rem_issue_q <= rem_issue_q - (ADDR_WIDTH+1)'(1);
        end
`else
        addr_q      <= next_addr(addr_q);
        rem_issue_q <= rem_issue_q - (ADDR_WIDTH+1)'(1);
`endif
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= RUN;
            addr_q      <= base_addr_i;
            rem_issue_q <= num_words_i;
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
            base_addr_q <= base_addr_i;
            num_q       <= num_words_i;
            pass_q      <= repeat_i;
            rem_out_q   <= OUT_W'(num_words_i) * OUT_W'({1'b0, repeat_i} + 9'd1);
`else
            rem_out_q   <= num_words_i;
`endif
          end
        end
        RUN: begin
          // rem_out_q is zero here only for an empty command: finish after one busy cycle.
          if (last_pop || (rem_out_q == '0)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (rem_issue_q == '0) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (occ_q == OCC_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_weightmem_read_sequencer.sv
// Directed bench for weightmem_read_sequencer: timing, wrap, backpressure, empty command, flush.
// Bank model returns a tagged word one cycle after each request.
module tb_weightmem_read_sequencer;
  localparam int AW = 10;
  localparam int DW = 80;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_words_i = '0;
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
  logic [7:0]    repeat_i = '0;
`endif
  logic          busy_o, done_o, mem_req_o, mem_we_o, valid_o, last_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_be_o, data_o;
  logic [DW-1:0] mem_rdata_i = '0;

  int checks_n = 0;
  int fail_n   = 0;
  logic [AW-1:0] ea [8];

  always #5 clk_i = ~clk_i;

  weightmem_read_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
    .repeat_i(repeat_i),
`endif
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .ready_i(ready_i)
  );

  function automatic logic [DW-1:0] dword(input logic [AW-1:0] a);
    return {16'hC0DE, 22'h0, ~a, 22'h0, a};
  endfunction

  always @(posedge clk_i) mem_rdata_i <= mem_req_o ? dword(mem_addr_o) : {DW{1'b1}};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Full-rate command with ready held high; ea[] holds the n expected addresses in order.
  task automatic timed_cmd(input logic [AW-1:0] base, input int nw, input int n);
    start_i = 1'b1; base_addr_i = base; num_words_i = (AW+1)'(nw); ready_i = 1'b1;
    for (int c = 0; c <= n + 3; c++) begin
      @(negedge clk_i);
      chk("req", mem_req_o, (c >= 1 && c <= n));
      if (c >= 1 && c <= n) chk("addr", mem_addr_o, ea[c-1]);
      chk("valid", valid_o, (c >= 3 && c <= n + 2));
      if (c >= 3 && c <= n + 2) chk("data", data_o, dword(ea[c-3]));
      chk("last", last_o, (c == n + 2));
      chk("done", done_o, (c == n + 3));
      chk("busy", busy_o, (c >= 1 && c <= n + 2));
      next_cycle();
      start_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks_n);
    $fatal(1);
  end

  initial begin
    int issued, popped;
    logic pop, done_seen;

    repeat (2) next_cycle();
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("we", mem_we_o, 0);
    chk("be", mem_be_o, {DW{1'b1}});
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    ea = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h0, 10'h0, 10'h0, 10'h0};
    timed_cmd(10'h010, 4, 4);

    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h0, 10'h0, 10'h0, 10'h0};
    timed_cmd(10'h3FE, 4, 4);

    // Backpressure with ready 1,0,0,1; a second start mid-command must be ignored.
    issued = 0; popped = 0; done_seen = 1'b0;
    start_i = 1'b1; base_addr_i = 10'h100; num_words_i = 11'd8;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      ready_i = ((c % 4) == 0) || ((c % 4) == 3);
      if (c == 4) begin start_i = 1'b1; base_addr_i = 10'h200; end
      @(negedge clk_i);
      pop = valid_o && ready_i;
      if (issued - popped - int'(pop) >= 2) chk("stall", mem_req_o, 0);
      if (mem_req_o) begin
        chk("addr_bp", mem_addr_o, AW'(10'h100 + issued));
        issued++;
      end
      if (pop) begin
        chk("data_bp", data_o, dword(AW'(10'h100 + popped)));
        chk("last_bp", last_o, (popped == 7));
        popped++;
      end
      if (done_o) done_seen = 1'b1;
      next_cycle();
      start_i = 1'b0;
    end
    chk("done_bp", done_seen, 1);
    chk("issued_bp", issued, 8);
    chk("popped_bp", popped, 8);
    ready_i = 1'b1;

    // Empty command.
    start_i = 1'b1; base_addr_i = 10'h123; num_words_i = 11'd0;
    @(negedge clk_i);
    chk("z_busy0", busy_o, 0);
    next_cycle();
    start_i = 1'b0;
    @(negedge clk_i);
    chk("z_busy1", busy_o, 1);
    chk("z_req1", mem_req_o, 0);
    chk("z_done1", done_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("z_busy2", busy_o, 0);
    chk("z_done2", done_o, 1);
    chk("z_req2", mem_req_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("z_done3", done_o, 0);
    next_cycle();

    // Flush in cycle 5 of a 16-word command, then a clean restart.
    start_i = 1'b1; base_addr_i = 10'h040; num_words_i = 11'd16;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (c == 3) chk("f_data3", data_o, dword(10'h040));
      next_cycle();
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("f_req", mem_req_o, 0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("f_valid1", valid_o, 0);
    chk("f_busy1", busy_o, 0);
    chk("f_done1", done_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("f_valid2", valid_o, 0);
    chk("f_done2", done_o, 0);
    next_cycle();
    ea = '{10'h050, 10'h051, 10'h052, 10'h053, 10'h0, 10'h0, 10'h0, 10'h0};
    timed_cmd(10'h050, 4, 4);

    // Flush and start together: start is dropped.
    start_i = 1'b1; flush_i = 1'b1; base_addr_i = 10'h077; num_words_i = 11'd3;
    next_cycle();
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("fs_busy", busy_o, 0);
    chk("fs_req", mem_req_o, 0);
    next_cycle();

`ifdef WEIGHTMEM_READ_SEQUENCER_REPEAT_EN
    repeat_i = 8'd1;
    ea = '{10'h020, 10'h021, 10'h022, 10'h020, 10'h021, 10'h022, 10'h0, 10'h0};
    timed_cmd(10'h020, 3, 6);
    repeat_i = 8'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
